// File: rtl/game_pkg.sv
// Shared types and constants for the round-level game sequencer.
package game_pkg;

    localparam int LIVES_W         = 3;
    localparam int START_LIVES_DEF = 3;

    // Codes are visible on the HUD; PAUSE only becomes reachable with GAME_PAUSE_EN.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5,
        ST_PAUSE = 3'd6
    } game_state_t;

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for a level-style key input, one sample per frame.
module key_edge (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key_i,
    output logic edge_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= key_i;
            armed_q <= 1'b1;
        end
    end

    // A key already held when Reset releases must fall and rise again before it counts.
    assign edge_o = key_i & ~prev_q & armed_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: game_on / game_reset generation, lives, level and pause timing.
// Optional pause support is compiled in with `define GAME_PAUSE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int START_LIVES  = START_LIVES_DEF,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int CLEAR_FRAMES = 120,
    parameter int MAX_LEVEL    = 15
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic                  start_key_i,
    input  logic [NUM_GHOSTS-1:0] die_i,
    input  logic                  level_clear_i,
`ifdef GAME_PAUSE_EN
    input  logic                  pause_key_i,
`endif
    output logic                  game_on_o,
    output logic                  game_reset_o,
    output logic [LIVES_W-1:0]    lives_o,
    output logic [3:0]            level_o,
    output logic [2:0]            state_code_o
);

    game_state_t        state_q, state_d;
    logic [7:0]         timer_q, timer_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic               game_on_q, game_on_d;
    logic               game_reset_q, game_reset_d;
    logic               start_edge;
    logic               pause_edge;

    key_edge u_start_edge (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key_i     (start_key_i),
        .edge_o    (start_edge)
    );

`ifdef GAME_PAUSE_EN
    key_edge u_pause_edge (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key_i     (pause_key_i),
        .edge_o    (pause_edge)
    );
`else
    assign pause_edge = 1'b0;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            lives_q      <= LIVES_W'(START_LIVES);
            level_q      <= 4'd0;
            game_on_q    <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            game_on_q    <= game_on_d;
            game_reset_q <= game_reset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (state_q == ST_OVER) lives_d = '0;
                if (start_edge) begin
                    state_d = ST_READY;
                    lives_d = LIVES_W'(START_LIVES);
                    level_d = 4'd0;
                end
            end
            ST_READY: begin
                if (timer_q == 8'(READY_FRAMES - 1)) state_d = ST_PLAY;
                else                                  timer_d = timer_q + 8'd1;
            end
            ST_PLAY: begin
                if (|die_i)             state_d = ST_DYING;
                else if (level_clear_i) state_d = ST_CLEAR;
                else if (pause_edge)    state_d = ST_PAUSE;
            end
            ST_DYING: begin
                if (timer_q == 8'(DEATH_FRAMES - 1)) begin
                    if (lives_q == LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_READY;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_CLEAR: begin
                if (timer_q == 8'(CLEAR_FRAMES - 1)) begin
                    level_d = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;
                    state_d = ST_READY;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (pause_edge) state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Every state entry restarts the frame timer.
        if (state_d != state_q) timer_d = 8'd0;
    end

    assign game_on_d    = (state_d == ST_PLAY);
    assign game_reset_d = (state_d == ST_READY) && (state_q != ST_READY);

    assign game_on_o    = game_on_q;
    assign game_reset_o = game_reset_q;
    assign lives_o      = lives_q;
    assign level_o      = level_q;
    assign state_code_o = state_q;

endmodule
